regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back port arbiter for the register file. Three write-back sources compete for the single GPR write port: ALU result (rd), load/immediate result (rt) and link ($31). The block grants one source per cycle using fixed priority with aging. It drives the 2-bit select code of the 3-input 5-bit write-address mux (00/01/10), plus a registered write enable, address and data to the register file. It sits between the execute/memory stages and the register file write port.

## Interface
- MAX_WAIT, 4: cycles a requester may wait before it becomes urgent (range 1..15).
- DATA_W, 32: write-data width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Hold  in  1  pipeline stall; no grants while 1
- ReqValid  in  3  per-source request; bit i = source i (0 ALU, 1 load/imm, 2 link)
- ReqReady  out  3  per-source grant; transfer when ReqValid[i] & ReqReady[i]
- ReqAddr0/1/2  in  5 each  destination register of each source
- ReqData0/1/2  in  DATA_W each  write data of each source
- Order  out  2  mux select: 2'b00 source 0, 2'b01 source 1, 2'b10 source 2; 2'b11 never driven
- WbEn  out  1  register-file write enable
- WbAddr  out  5  register-file write address
- WbData  out  DATA_W  register-file write data
- Urgent  out  3  per-source aging flag (debug/perf)

## Operation
- ReqReady is combinational from ReqValid, Urgent and Hold. At most one bit is high per cycle, and it is never high for a source whose ReqValid is 0.
- Grant rule, when Hold=0:
  - If any valid source is urgent, grant the lowest-index urgent valid source.
  - Otherwise, grant the lowest-index valid source (fixed priority 0 > 1 > 2).
- Aging: each source has a wait counter, width ceil(log2(MAX_WAIT+1)).
  - The counter increments each cycle ReqValid[i]=1, ReqReady[i]=0 and Hold=0, saturating at MAX_WAIT.
  - It clears on a grant or when ReqValid[i]=0.
  - It holds its value while Hold=1.
  - Urgent[i] = (counter == MAX_WAIT).
- Sources hold ReqValid, ReqAddr and ReqData stable until granted. The arbiter does not buffer ungranted requests.
- On a grant, the next edge registers:
  - Order = granted index
  - WbAddr = granted address
  - WbData = granted data
  - WbEn = 1, unless the granted address is 5'd0, in which case WbEn = 0. The $0 request is still consumed (ReqReady asserted).
- With no grant (no valid source or Hold=1), the next edge sets WbEn = 0. Order, WbAddr and WbData hold their previous values.
- When two sources target the same register, they are serialized. The later-granted value is written last.

## Timing
- Reset (asynchronous, rst_n=0):
  - WbEn=0, WbAddr=0, WbData=0, Order=2'b00, all wait counters 0, Urgent=0.
  - ReqReady=0 while rst_n=0.
- Grant-to-write latency: 1 cycle. A grant in cycle N produces WbEn/WbAddr/WbData/Order valid during cycle N+1.
- Throughput: one write per cycle when Hold=0.
- Hold asserted in the same cycle as a valid request: no grant, and WbEn=0 next cycle.
- Reset mid-operation: an in-flight registered write is dropped (WbEn forced 0 immediately). Counters clear. Requesters re-present after reset.
- With MAX_WAIT=4, source 2 under continuous source-0 traffic is granted no later than its 5th waiting cycle.

## Test plan
- Reset: hold rst_n=0 with all ReqValid=3'b111. Required: ReqReady=000, WbEn=0, Order=00, WbAddr=0. Release rst_n; on the first cycle, ReqReady=001.
- Priority: ReqValid=111 with addresses 5/6/31 and data A/B/C, each source dropping valid after its grant. Required: grants in order 0, 1, 2 on consecutive cycles, then WbEn=1 writing (5,A,Order 00), (6,B,01), (31,C,10) on cycles N+1..N+3.
- Aging: source 0 valid every cycle (new addresses), source 2 valid continuously, MAX_WAIT=4. Required:
  - Urgent[2]=1 after 4 waiting cycles.
  - Source 2 granted on the 5th cycle, Order=10 the cycle after.
  - Source 0 resumes the following cycle.
- $0 suppression: source 1 valid with ReqAddr1=0, data 32'hDEADBEEF. Required: ReqReady=010 and Order=01 next cycle, with WbEn=0.
- Hold: ReqValid=011 and Hold=1 for 3 cycles, then 0. Required:
  - ReqReady=000 and WbEn=0 throughout the hold.
  - Counters stay frozen (Urgent stays 0).
  - The first grant after release goes to source 0.
- Async reset mid-write: assert rst_n=0 mid-cycle while WbEn=1. Required: WbEn falls to 0 before the next clock edge, and Urgent clears.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbitration bus: per-source requests toward the arbiter and the
// registered register-file write port back out of it.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        ReqValid;
  logic [2:0]        ReqReady;
  logic [4:0]        ReqAddr0;
  logic [4:0]        ReqAddr1;
  logic [4:0]        ReqAddr2;
  logic [DATA_W-1:0] ReqData0;
  logic [DATA_W-1:0] ReqData1;
  logic [DATA_W-1:0] ReqData2;
  logic [1:0]        Order;
  logic              WbEn;
  logic [4:0]        WbAddr;
  logic [DATA_W-1:0] WbData;
  logic [2:0]        Urgent;

  modport master (
    output ReqValid, ReqAddr0, ReqAddr1, ReqAddr2, ReqData0, ReqData1, ReqData2,
    input  ReqReady, Order, WbEn, WbAddr, WbData, Urgent
  );

  modport slave (
    input  ReqValid, ReqAddr0, ReqAddr1, ReqAddr2, ReqData0, ReqData1, ReqData2,
    output ReqReady, Order, WbEn, WbAddr, WbData, Urgent
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU, load/imm and link results onto the single GPR write port
// using fixed priority, with per-source aging so no source starves.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Hold,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_q [3];
  logic [CNT_W-1:0]  wait_d [3];
  logic [2:0]        urgent;
  logic [2:0]        candidates;
  logic [2:0]        grant;
  logic              grant_any;
  logic [1:0]        grant_idx;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wb_en_q, wb_en_d;
  logic [1:0]        order_q, order_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  // Urgent valid requesters, if any, pre-empt the plain fixed-priority set.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      urgent[i] = (wait_q[i] == CNT_MAX);
    end
    candidates = ((bus.ReqValid & urgent) != 3'b000) ? (bus.ReqValid & urgent)
                                                     : bus.ReqValid;
    grant_any  = rst_n && !Hold && (candidates != 3'b000);
    if (candidates[0]) begin
      grant_idx = 2'd0;
    end else if (candidates[1]) begin
      grant_idx = 2'd1;
    end else begin
      grant_idx = 2'd2;
    end
    grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    begin sel_addr = bus.ReqAddr0; sel_data = bus.ReqData0; end
      2'd1:    begin sel_addr = bus.ReqAddr1; sel_data = bus.ReqData1; end
      default: begin sel_addr = bus.ReqAddr2; sel_data = bus.ReqData2; end
    endcase
  end

  // Wait counters freeze under Hold so a stall never manufactures urgency.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wait_d[i] = wait_q[i];
      if (!Hold) begin
        if (!bus.ReqValid[i] || grant[i]) begin
          wait_d[i] = '0;
        end else if (wait_q[i] != CNT_MAX) begin
          wait_d[i] = wait_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    wb_en_d   = 1'b0;
    order_d   = order_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (grant_any) begin
      order_d   = grant_idx;
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
      wb_en_d   = (sel_addr != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        wait_q[i] <= '0;
      end
      wb_en_q   <= 1'b0;
      order_q   <= 2'b00;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        wait_q[i] <= wait_d[i];
      end
      wb_en_q   <= wb_en_d;
      order_q   <= order_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.ReqReady = grant;
  assign bus.Urgent   = urgent;
  assign bus.WbEn     = wb_en_q;
  assign bus.Order    = order_q;
  assign bus.WbAddr   = wb_addr_q;
  assign bus.WbData   = wb_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int DATA_W   = 32;

  logic clk;
  logic rst_n;
  logic Hold;

  logic [2:0]        src_valid;
  logic [4:0]        src_addr [3];
  logic [DATA_W-1:0] src_data [3];

  int check_count = 0;
  int pass_count  = 0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Hold  (Hold),
    .bus   (bus)
  );

  assign bus.ReqValid = src_valid;
  assign bus.ReqAddr0 = src_addr[0];
  assign bus.ReqAddr1 = src_addr[1];
  assign bus.ReqAddr2 = src_addr[2];
  assign bus.ReqData0 = src_data[0];
  assign bus.ReqData1 = src_data[1];
  assign bus.ReqData2 = src_data[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: waiting time per source and the last write issued.
  int                wait_cnt [3] = '{0, 0, 0};
  int                exp_grant;
  logic [2:0]        exp_ready;
  logic [2:0]        exp_urg;
  logic              m_en    = 1'b0;
  logic [1:0]        m_order = 2'b00;
  logic [4:0]        m_addr  = 5'd0;
  logic [DATA_W-1:0] m_data  = '0;

  always_comb begin
    exp_grant = -1;
    if (rst_n && !Hold) begin
      for (int i = 2; i >= 0; i--) if (src_valid[i]) exp_grant = i;
      for (int i = 2; i >= 0; i--) if (src_valid[i] && wait_cnt[i] == MAX_WAIT) exp_grant = i;
    end
    exp_ready = 3'b000;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    for (int i = 0; i < 3; i++) exp_urg[i] = (wait_cnt[i] == MAX_WAIT);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) wait_cnt[i] <= 0;
      m_en    <= 1'b0;
      m_order <= 2'b00;
      m_addr  <= 5'd0;
      m_data  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!Hold) begin
          if (!src_valid[i] || exp_grant == i) wait_cnt[i] <= 0;
          else if (wait_cnt[i] < MAX_WAIT) wait_cnt[i] <= wait_cnt[i] + 1;
        end
      end
      if (exp_grant >= 0) begin
        m_order <= 2'(exp_grant);
        m_addr  <= src_addr[exp_grant];
        m_data  <= src_data[exp_grant];
        m_en    <= (src_addr[exp_grant] != 5'd0);
      end else begin
        m_en <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic hold);
    src_valid = valid;
    Hold      = hold;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model ReqReady", bus.ReqReady, exp_ready);
      checkOutput("model Urgent",   bus.Urgent,   exp_urg);
      checkOutput("model WbEn",     bus.WbEn,     m_en);
      checkOutput("model Order",    bus.Order,    m_order);
      checkOutput("model WbAddr",   bus.WbAddr,   m_addr);
      checkOutput("model WbData",   bus.WbData,   m_data);
    end
  end

  logic [2:0] fire;

  initial begin
    rst_n = 1'b0;
    src_addr = '{5'd5, 5'd6, 5'd31};
    src_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    applyStimulus(3'b111, 1'b0);
    #12;
    checkOutput("reset ReqReady", bus.ReqReady, 3'b000);
    checkOutput("reset WbEn",     bus.WbEn,     1'b0);
    checkOutput("reset Order",    bus.Order,    2'b00);
    checkOutput("reset WbAddr",   bus.WbAddr,   5'd0);
    checkOutput("reset Urgent",   bus.Urgent,   3'b000);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset ReqReady", bus.ReqReady, 3'b001);

    // Fixed priority with each source retiring after its grant.
    nextCycle(); applyStimulus(3'b110, 1'b0); #1;
    checkOutput("prio ReqReady1", bus.ReqReady, 3'b010);
    checkOutput("prio WbEn0",     bus.WbEn,     1'b1);
    checkOutput("prio WbAddr0",   bus.WbAddr,   5'd5);
    checkOutput("prio WbData0",   bus.WbData,   32'hAAAA_0001);
    checkOutput("prio Order0",    bus.Order,    2'b00);
    nextCycle(); applyStimulus(3'b100, 1'b0); #1;
    checkOutput("prio ReqReady2", bus.ReqReady, 3'b100);
    checkOutput("prio WbAddr1",   bus.WbAddr,   5'd6);
    checkOutput("prio WbData1",   bus.WbData,   32'hBBBB_0002);
    checkOutput("prio Order1",    bus.Order,    2'b01);
    nextCycle(); applyStimulus(3'b000, 1'b0); #1;
    checkOutput("prio ReqReady idle", bus.ReqReady, 3'b000);
    checkOutput("prio WbEn2",     bus.WbEn,     1'b1);
    checkOutput("prio WbAddr2",   bus.WbAddr,   5'd31);
    checkOutput("prio WbData2",   bus.WbData,   32'hCCCC_0003);
    checkOutput("prio Order2",    bus.Order,    2'b10);
    nextCycle(); #1;
    checkOutput("idle WbEn",      bus.WbEn,     1'b0);
    checkOutput("idle Order held", bus.Order,   2'b10);

    // Aging: source 2 starved by back-to-back source-0 traffic.
    src_addr[2] = 5'd20;
    src_data[2] = 32'h2222_2222;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      applyStimulus(3'b101, 1'b0);
      src_addr[0] = 5'(c + 1);
      src_data[0] = $urandom;
      #1;
      checkOutput("aging ReqReady src0", bus.ReqReady, 3'b001);
      checkOutput("aging not urgent",    bus.Urgent,   3'b000);
    end
    nextCycle();
    src_addr[0] = 5'd9;
    #1;
    checkOutput("aging Urgent2",   bus.Urgent,   3'b100);
    checkOutput("aging grant src2", bus.ReqReady, 3'b100);
    nextCycle(); applyStimulus(3'b001, 1'b0); #1;
    checkOutput("aging Order2",    bus.Order,    2'b10);
    checkOutput("aging WbAddr2",   bus.WbAddr,   5'd20);
    checkOutput("aging src0 resumes", bus.ReqReady, 3'b001);
    checkOutput("aging Urgent cleared", bus.Urgent, 3'b000);
    nextCycle(); applyStimulus(3'b000, 1'b0); #1;
    checkOutput("aging src0 WbAddr", bus.WbAddr, 5'd9);

    // Writes to $0 are consumed but never enabled.
    nextCycle();
    applyStimulus(3'b010, 1'b0);
    src_addr[1] = 5'd0;
    src_data[1] = 32'hDEAD_BEEF;
    #1;
    checkOutput("zero ReqReady", bus.ReqReady, 3'b010);
    nextCycle(); applyStimulus(3'b000, 1'b0); #1;
    checkOutput("zero Order",  bus.Order,  2'b01);
    checkOutput("zero WbEn",   bus.WbEn,   1'b0);
    checkOutput("zero WbData", bus.WbData, 32'hDEAD_BEEF);

    // Stall: no grants, no writes, counters frozen.
    nextCycle();
    applyStimulus(3'b011, 1'b1);
    src_addr[0] = 5'd3;
    src_addr[1] = 5'd4;
    #1;
    for (int h = 0; h < 3; h++) begin
      checkOutput("hold ReqReady", bus.ReqReady, 3'b000);
      checkOutput("hold WbEn",     bus.WbEn,     1'b0);
      checkOutput("hold Urgent",   bus.Urgent,   3'b000);
      nextCycle(); #1;
    end
    Hold = 1'b0;
    #1;
    checkOutput("hold release grant", bus.ReqReady, 3'b001);
    nextCycle(); applyStimulus(3'b010, 1'b0); #1;
    checkOutput("hold WbAddr after", bus.WbAddr,   5'd3);
    checkOutput("hold src1 next",    bus.ReqReady, 3'b010);
    nextCycle(); applyStimulus(3'b000, 1'b0); #1;
    checkOutput("hold WbAddr src1", bus.WbAddr, 5'd4);

    // Asynchronous reset while a write is in flight and source 2 is urgent.
    nextCycle();
    applyStimulus(3'b101, 1'b0);
    src_addr[0] = 5'd10;
    src_addr[2] = 5'd11;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      src_addr[0] = 5'(12 + c);
    end
    #2;
    checkOutput("pre-reset WbEn",   bus.WbEn,   1'b1);
    checkOutput("pre-reset Urgent", bus.Urgent, 3'b100);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset WbEn",     bus.WbEn,     1'b0);
    checkOutput("async reset Urgent",   bus.Urgent,   3'b000);
    checkOutput("async reset ReqReady", bus.ReqReady, 3'b000);
    applyStimulus(3'b000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Randomized traffic: requests persist until granted, random stalls.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      fire = src_valid & bus.ReqReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!src_valid[i] || fire[i]) begin
          if ($urandom_range(0, 99) < 65) begin
            src_valid[i] = 1'b1;
            src_addr[i]  = 5'($urandom_range(0, 7));
            src_data[i]  = $urandom;
          end else begin
            src_valid[i] = 1'b0;
          end
        end
      end
      Hold = ($urandom_range(0, 99) < 15);
    end
    nextCycle();

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
